// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants: opcodes, funct fields and ALU control codes.
package riscv_pkg;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ADD     = 7'b0000000;
  localparam logic [6:0] F7_SUB     = 7'b0100000;
  localparam logic [2:0] F3_ADD     = 3'b000;
  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_NOP    = 4'd15;
endpackage

// File: rtl/riscv_regfile.sv
// 32x32 register file: two combinational reads, one synchronous write, x0 reads zero.
// RISCV_DEC_BYPASS_EN forwards a same-edge writeback onto the read ports.
module riscv_regfile #(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic [4:0]           rs1_addr_i,
  input  logic [4:0]           rs2_addr_i,
  output logic [BUS_WIDTH-1:0] rs1_data_o,
  output logic [BUS_WIDTH-1:0] rs2_data_o,
  input  logic                 wb_en_i,
  input  logic [4:0]           wb_addr_i,
  input  logic [BUS_WIDTH-1:0] wb_data_i
);
  logic [BUS_WIDTH-1:0] regs_q [32];
  logic                 wr_ok;
  logic [BUS_WIDTH-1:0] rs1_raw, rs2_raw;

  assign wr_ok = wb_en_i && (wb_addr_i != 5'd0);

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[wb_addr_i] <= wb_data_i;
    end
  end

  assign rs1_raw = (rs1_addr_i == 5'd0) ? '0 : regs_q[rs1_addr_i];
  assign rs2_raw = (rs2_addr_i == 5'd0) ? '0 : regs_q[rs2_addr_i];

`ifdef RISCV_DEC_BYPASS_EN
  assign rs1_data_o = (wr_ok && (wb_addr_i == rs1_addr_i)) ? wb_data_i : rs1_raw;
  assign rs2_data_o = (wr_ok && (wb_addr_i == rs2_addr_i)) ? wb_data_i : rs2_raw;
`else
  assign rs1_data_o = rs1_raw;
  assign rs2_data_o = rs2_raw;
`endif
endmodule

// File: rtl/riscv_decode_stage.sv
// Decode/operand stage for ADD/SUB/ADDI feeding the ALU through one register stage.
// Same-edge writeback forwarding is selected by RISCV_DEC_BYPASS_EN (see riscv_regfile).
module riscv_decode_stage
  import riscv_pkg::*;
#(
  parameter int BUS_WIDTH  = 32,
  parameter int CTRL_WIDTH = 4
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_Valid,
  input  logic [31:0]           i_Instr,
  input  logic                  i_Stall,
  output logic                  o_Ready,
  input  logic                  i_WB_En,
  input  logic [4:0]            i_WB_Addr,
  input  logic [BUS_WIDTH-1:0]  i_WB_Data,
  output logic                  o_Valid,
  output logic [BUS_WIDTH-1:0]  o_OP1,
  output logic [BUS_WIDTH-1:0]  o_OP2,
  output logic [CTRL_WIDTH-1:0] o_Control,
  output logic [4:0]            o_Rd,
  output logic                  o_RegWrite,
  output logic                  o_Illegal
);
  logic [6:0]           opcode, funct7;
  logic [2:0]           funct3;
  logic [4:0]           rs1, rs2, rd;
  logic [BUS_WIDTH-1:0] rs1_val, rs2_val, imm;
  logic                 is_add, is_sub, is_addi, accept;

  logic                  valid_q, valid_d, regwrite_q, regwrite_d, illegal_q, illegal_d;
  logic [BUS_WIDTH-1:0]  op1_q, op1_d, op2_q, op2_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [4:0]            rd_q, rd_d;

  assign opcode = i_Instr[6:0];
  assign rd     = i_Instr[11:7];
  assign funct3 = i_Instr[14:12];
  assign rs1    = i_Instr[19:15];
  assign rs2    = i_Instr[24:20];
  assign funct7 = i_Instr[31:25];
  assign imm    = {{(BUS_WIDTH-12){i_Instr[31]}}, i_Instr[31:20]};

  assign is_add  = (opcode == OPC_OP) && (funct3 == F3_ADD) && (funct7 == F7_ADD);
  assign is_sub  = (opcode == OPC_OP) && (funct3 == F3_ADD) && (funct7 == F7_SUB);
  assign is_addi = (opcode == OPC_OP_IMM) && (funct3 == F3_ADD);

  assign o_Ready = ~i_Stall & ~i_RST;
  assign accept  = i_Valid & o_Ready;

  riscv_regfile #(.BUS_WIDTH(BUS_WIDTH)) u_regfile (
    .i_CLK      (i_CLK),
    .i_RST      (i_RST),
    .rs1_addr_i (rs1),
    .rs2_addr_i (rs2),
    .rs1_data_o (rs1_val),
    .rs2_data_o (rs2_val),
    .wb_en_i    (i_WB_En),
    .wb_addr_i  (i_WB_Addr),
    .wb_data_i  (i_WB_Data)
  );

  // Stall holds the bundle, but o_Illegal is an event pulse and never extends.
  always_comb begin
    valid_d    = valid_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    ctrl_d     = ctrl_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    illegal_d  = 1'b0;
    if (!i_Stall) begin
      valid_d    = 1'b0;
      op1_d      = '0;
      op2_d      = '0;
      ctrl_d     = CTRL_WIDTH'(ALU_NOP);
      rd_d       = 5'd0;
      regwrite_d = 1'b0;
      if (accept) begin
        if (is_add || is_sub || is_addi) begin
          valid_d    = 1'b1;
          op1_d      = rs1_val;
          op2_d      = is_addi ? imm : rs2_val;
          ctrl_d     = is_sub ? CTRL_WIDTH'(ALU_SUB) : CTRL_WIDTH'(ALU_ADD);
          rd_d       = rd;
          regwrite_d = (rd != 5'd0);
        end else begin
          illegal_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      valid_q    <= 1'b0;
      op1_q      <= '0;
      op2_q      <= '0;
      ctrl_q     <= CTRL_WIDTH'(ALU_NOP);
      rd_q       <= 5'd0;
      regwrite_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      ctrl_q     <= ctrl_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      illegal_q  <= illegal_d;
    end
  end

  assign o_Valid    = valid_q;
  assign o_OP1      = op1_q;
  assign o_OP2      = op2_q;
  assign o_Control  = ctrl_q;
  assign o_Rd       = rd_q;
  assign o_RegWrite = regwrite_q;
  assign o_Illegal  = illegal_q;
endmodule

// File: tb/tb_riscv_decode_stage.sv
// Scoreboard bench for riscv_decode_stage: directed test-plan sequence then random traffic.
// Reference model follows RISCV_DEC_BYPASS_EN for same-edge writeback forwarding.
module tb_riscv_decode_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1, vld = 1'b0, stall = 1'b0, wb_en = 1'b0;
  logic [31:0] instr = '0, wb_data = '0;
  logic [4:0]  wb_addr = '0;

  logic        o_ready, o_valid, o_regwrite, o_illegal;
  logic [31:0] o_op1, o_op2;
  logic [3:0]  o_control;
  logic [4:0]  o_rd;

  riscv_decode_stage #(.BUS_WIDTH(32), .CTRL_WIDTH(4)) dut (
    .i_CLK(clk), .i_RST(rst), .i_Valid(vld), .i_Instr(instr), .i_Stall(stall),
    .o_Ready(o_ready), .i_WB_En(wb_en), .i_WB_Addr(wb_addr), .i_WB_Data(wb_data),
    .o_Valid(o_valid), .o_OP1(o_op1), .o_OP2(o_op2), .o_Control(o_control),
    .o_Rd(o_rd), .o_RegWrite(o_regwrite), .o_Illegal(o_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [31:0] op1, op2;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        rw, ill, rdy;
  } exp_t;

  exp_t        q[$];
  exp_t        m;           // modelled current output bundle
  logic [31:0] mreg [32];   // modelled architectural registers
  int          vectors = 0, miscompares = 0;

  function automatic exp_t bubble();
    exp_t b;
    b.vld = 1'b0; b.op1 = '0; b.op2 = '0; b.ctrl = 4'd15;
    b.rd = '0; b.rw = 1'b0; b.ill = 1'b0; b.rdy = 1'b0;
    return b;
  endfunction

  function automatic logic [31:0] read_reg(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 32'd0;
`ifdef RISCV_DEC_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return mreg[a];
  endfunction

  // Drive one cycle of inputs and push the bundle expected after the next edge.
  task automatic apply(input logic r, input logic v, input logic [31:0] ins, input logic st,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    exp_t e;
    int   opc, f3, f7;
    @(negedge clk);
    #2;
    rst = r; vld = v; instr = ins; stall = st; wb_en = we; wb_addr = wa; wb_data = wd;
    e = m;
    e.ill = 1'b0;
    if (r) begin
      e = bubble();
      for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    end else begin
      if (!st) begin
        e = bubble();
        if (v) begin
          opc = int'(ins & 32'h7F);
          f3  = int'((ins >> 12) & 32'h7);
          f7  = int'(ins >> 25);
          if ((opc == 'h33 && f3 == 0 && (f7 == 0 || f7 == 'h20)) || (opc == 'h13 && f3 == 0)) begin
            e.vld = 1'b1;
            e.rd  = ins[11:7];
            e.rw  = (ins[11:7] != 0);
            e.op1 = read_reg(ins[19:15], we, wa, wd);
            e.op2 = (opc == 'h13) ? 32'($signed(ins) >>> 20) : read_reg(ins[24:20], we, wa, wd);
            e.ctrl = (opc == 'h33 && f7 == 'h20) ? 4'd1 : 4'd0;
          end else begin
            e.ill = 1'b1;
          end
        end
      end
      if (we && wa != 0) mreg[wa] = wd;
    end
    e.rdy = !st && !r;
    m = e;
    q.push_back(e);
  endtask

  // Monitor: one expected bundle per cycle, sampled at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (o_valid !== e.vld || o_op1 !== e.op1 || o_op2 !== e.op2 || o_control !== e.ctrl ||
            o_rd !== e.rd || o_regwrite !== e.rw || o_illegal !== e.ill || o_ready !== e.rdy) begin
          miscompares++;
          $display("FAIL bundle#%0d got vld=%0b op1=%h op2=%h ctl=%0d rd=%0d rw=%0b ill=%0b rdy=%0b exp vld=%0b op1=%h op2=%h ctl=%0d rd=%0d rw=%0b ill=%0b rdy=%0b",
                   vectors, o_valid, o_op1, o_op2, o_control, o_rd, o_regwrite, o_illegal, o_ready,
                   e.vld, e.op1, e.op2, e.ctrl, e.rd, e.rw, e.ill, e.rdy);
        end
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [4:0]  r1, r2, rdd;
    logic [11:0] imm;
    r1 = 5'($urandom_range(0, 7)); r2 = 5'($urandom_range(0, 7));
    rdd = 5'($urandom_range(0, 7)); imm = 12'($urandom);
    case ($urandom_range(0, 4))
      0:       return {7'h00, r2, r1, 3'b000, rdd, 7'h33};
      1:       return {7'h20, r2, r1, 3'b000, rdd, 7'h33};
      2:       return {imm, r1, 3'b000, rdd, 7'h13};
      3:       return {7'($urandom), r2, r1, 3'($urandom_range(0, 1)), rdd, 7'h33};
      default: return 32'($urandom);
    endcase
  endfunction

  localparam logic [31:0] ADD_X3 = 32'h002081B3;

  initial begin
    int guard;
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    m = bubble();
    apply(1, 0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 1, 1, 32'h1234);
    apply(0, 0, 0, 0, 1, 1, 5);
    apply(0, 0, 0, 0, 1, 2, 3);
    apply(0, 1, ADD_X3, 0, 0, 0, 0);
    apply(0, 1, 32'h40208233, 0, 0, 0, 0);
    apply(0, 1, 32'hFFF08293, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 1, 0, 32'hDEAD);
    apply(0, 1, 32'h00000333, 0, 0, 0, 0);
    apply(0, 1, 32'h00108013, 0, 0, 0, 0);
    apply(0, 1, 32'h00000073, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0);
    apply(0, 1, ADD_X3, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) apply(0, 1, 32'h00000073, 1, 0, 0, 0);
    apply(0, 1, ADD_X3, 0, 0, 0, 0);
    apply(1, 1, ADD_X3, 0, 1, 1, 7);
    apply(0, 1, ADD_X3, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 1, 1, 5);
    apply(0, 1, 32'h001083B3, 0, 1, 1, 9);
    apply(0, 1, 32'h001083B3, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      apply(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 8), rand_instr(),
            ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 7)), $urandom);
    end
    apply(0, 0, 0, 0, 0, 0, 0);
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d bundles still pending, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/riscv_decode_stage.md
# riscv_decode_stage

Decode/operand stage directly upstream of the team's two-operation RISC-V ALU (ADD/SUB, 4-bit control, 1-cycle registered result). It accepts 32-bit instruction words, decodes ADD, SUB and ADDI, and reads two operands from an internal 32×32 register file with x0 hardwired to zero. It drives a registered operand/control bundle straight into the ALU inputs, and accepts a writeback port that updates the register file.

## Interface
- BUS_WIDTH, 32, operand/register width
- CTRL_WIDTH, 4, ALU control width
- i_CLK  in  1  clock; all state updates on rising edge
- i_RST  in  1  reset, synchronous, active-high
- i_Valid  in  1  i_Instr holds an instruction
- i_Instr  in  32  RV32I instruction word
- i_Stall  in  1  downstream/hazard hold request
- o_Ready  out  1  combinational; equals ~i_Stall & ~i_RST
- i_WB_En  in  1  writeback enable
- i_WB_Addr  in  5  writeback register index
- i_WB_Data  in  BUS_WIDTH  writeback data
- o_Valid  out  1  output bundle holds a decoded instruction
- o_OP1  out  BUS_WIDTH  ALU operand 1 (rs1 value)
- o_OP2  out  BUS_WIDTH  ALU operand 2 (rs2 value or sign-extended imm)
- o_Control  out  CTRL_WIDTH  ALU control: 0 ADD, 1 SUB, 15 NOP
- o_Rd  out  5  destination register index
- o_RegWrite  out  1  result must be written back to o_Rd
- o_Illegal  out  1  one-cycle pulse: unsupported instruction consumed

## Operation
- Accept: i_Valid & o_Ready at a rising edge.
- Decode on accept:
  - opcode 0110011, funct3 000, funct7 0000000: ADD; OP2 = x[rs2]; ctrl 0.
  - opcode 0110011, funct3 000, funct7 0100000: SUB; OP2 = x[rs2]; ctrl 1.
  - opcode 0010011, funct3 000: ADDI; OP2 = sign-extend(i_Instr[31:20]) to BUS_WIDTH; ctrl 0.
  - Any other encoding: illegal.
- Outputs on a legal accept: o_Valid=1, o_RegWrite=(rd!=0), o_Rd=rd, o_OP1=x[rs1].
- Outputs on an illegal accept: bubble. o_Valid=0, o_RegWrite=0, o_Control=15, o_OP1=o_OP2=0, o_Rd=0, o_Illegal=1 for one cycle.
- No accept with i_Stall=0 (i_Valid=0): bubble as above, o_Illegal=0.
- i_Stall=1: all outputs hold their current values; the instruction is not consumed. Writeback still occurs.
- Register file:
  - Writes occur when i_WB_En=1 and i_WB_Addr!=0.
  - Writes to x0 are discarded; reads of x0 return 0.
- Arithmetic: no width growth; immediates are sign-extended from bit 31 of the instruction.

## Timing
- Latency: accept at edge N → bundle valid after edge N → ALU result after edge N+1.
- Throughput: one instruction per cycle while i_Stall=0.
- A writeback at edge N is visible to reads decoded at edge N+1 or later. Same-edge behaviour is governed by Configuration.
- Reset (i_RST=1 at an edge), including mid-stream:
  - All 31 registers are cleared to 0.
  - Outputs return to the bubble state: o_Valid=0, o_Control=15, o_OP1=o_OP2=0, o_Rd=0, o_RegWrite=0, o_Illegal=0.
  - Writebacks and accepts in that cycle are ignored; o_Ready=0.
- Stall and illegal in the same cycle: no accept, so no o_Illegal pulse.

## Configuration
- RISCV_DEC_BYPASS_EN defined: write-through bypass. If i_WB_En=1, i_WB_Addr!=0 and i_WB_Addr equals rs1 or rs2 of the instruction accepted at the same edge, the operand takes i_WB_Data.
- RISCV_DEC_BYPASS_EN undefined: the operand takes the pre-write register value. Hazard avoidance is the software/hazard unit's responsibility.

## Structure
- Shared package riscv_pkg holds:
  - opcode constants OPC_OP=7'b0110011 and OPC_OP_IMM=7'b0010011
  - funct7 constants F7_ADD and F7_SUB
  - ALU control constants ALU_ADD=0, ALU_SUB=1, ALU_NOP=15
- Sub-module riscv_regfile: 2 combinational read ports, 1 synchronous write port, synchronous reset, x0 masking. It carries the bypass logic under the macro.
- Top level contains only decode, immediate generation and the output pipeline register.

## Test plan
- Reset, then write x1=5 and x2=3 via WB. ADD x3,x1,x2 (0x002081B3) → o_OP1=5, o_OP2=3, o_Control=0, o_Rd=3, o_RegWrite=1.
- SUB x4,x1,x2 (0x40208233) → o_Control=1, o_OP1=5, o_OP2=3.
- ADDI x5,x1,-1 (0xFFF08293) → o_OP2=0xFFFFFFFF, o_Control=0.
- WB x0=0xDEAD, then ADD x6,x0,x0 → o_OP1=o_OP2=0. ADDI x0,x1,1 → o_RegWrite=0.
- Illegal word 0x00000073 → o_Valid=0, o_Control=15, o_Illegal=1 for exactly one cycle. With i_Stall=1 hold three cycles: outputs unchanged, o_Ready=0. Assert i_RST mid-stream → bubble state and x1 reads 0.
- WB x1=9 at the same edge ADD x7,x1,x1 is accepted → o_OP1=9 with RISCV_DEC_BYPASS_EN defined, 5 without it.
